// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb placement path: grid bounds, map cell
// states, slot record and the map cell-index helper.
package bomb_pkg;

  localparam logic [3:0] GRID_MIN = 4'd1;
  localparam logic [3:0] GRID_MAX = 4'd8;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    FUSE1   = 2'b01,
    FUSE2   = 2'b10,
    EXPLODE = 2'b11
  } map_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] cnt;
  } slot_t;

  function automatic logic [6:0] idx(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] full;
    full = 8'd10 * {4'd0, x} + {4'd0, y};
    return full[6:0];
  endfunction

  function automatic logic in_grid(input logic [3:0] x, input logic [3:0] y);
    return (x >= GRID_MIN) && (x <= GRID_MAX) && (y >= GRID_MIN) && (y <= GRID_MAX);
  endfunction

endpackage

// File: rtl/bomb_slot_tracker.sv
// Per-player bomb slots with fuse countdown, placement cooldown, lowest-index
// free-slot search, cell-occupancy match for both players' cells and live count.
module bomb_slot_tracker
  import bomb_pkg::*;
#(
  parameter int unsigned MAX_BOMBS  = 2,
  parameter int unsigned FUSE_TICKS = 4,
  parameter int unsigned COOLDOWN   = 1
) (
  input  logic       bombClk,
  input  logic       rst,
  input  logic       grant_i,
  input  logic [3:0] gx_i,
  input  logic [3:0] gy_i,
  input  logic [3:0] qax_i,
  input  logic [3:0] qay_i,
  input  logic [3:0] qbx_i,
  input  logic [3:0] qby_i,
  output logic       has_free_o,
  output logic       cool_ok_o,
  output logic       match_a_o,
  output logic       match_b_o,
  output logic [1:0] active_o
);

  slot_t [MAX_BOMBS-1:0] slots_q, slots_d;
  logic  [2:0]           cool_q, cool_d;
  logic  [1:0]           free_idx;
  logic                  has_free;

  // A slot whose counter reads 1 expires on this edge, so it may be reused now.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < MAX_BOMBS; i++) begin
      if (!has_free && (!slots_q[i].valid || slots_q[i].cnt == 3'd1)) begin
        has_free = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  always_comb begin
    match_a_o = 1'b0;
    match_b_o = 1'b0;
    active_o  = '0;
    for (int unsigned i = 0; i < MAX_BOMBS; i++) begin
      if (slots_q[i].valid) begin
        active_o = active_o + 2'd1;
        if (slots_q[i].x == qax_i && slots_q[i].y == qay_i) match_a_o = 1'b1;
        if (slots_q[i].x == qbx_i && slots_q[i].y == qby_i) match_b_o = 1'b1;
      end
    end
  end

  always_comb begin
    slots_d = slots_q;
    for (int unsigned i = 0; i < MAX_BOMBS; i++) begin
      if (slots_q[i].valid) begin
        if (slots_q[i].cnt == 3'd1) slots_d[i] = '0;
        else                        slots_d[i].cnt = slots_q[i].cnt - 3'd1;
      end
      if (grant_i && free_idx == 2'(i)) begin
        slots_d[i].valid = 1'b1;
        slots_d[i].x     = gx_i;
        slots_d[i].y     = gy_i;
        slots_d[i].cnt   = 3'(FUSE_TICKS);
      end
    end
    if (grant_i)              cool_d = 3'(COOLDOWN);
    else if (cool_q != '0)    cool_d = cool_q - 3'd1;
    else                      cool_d = '0;
  end

  always_ff @(posedge bombClk or posedge rst) begin
    if (rst) begin
      slots_q <= '0;
      cool_q  <= '0;
    end else begin
      slots_q <= slots_d;
      cool_q  <= cool_d;
    end
  end

  assign has_free_o = has_free;
  assign cool_ok_o  = (cool_q == '0);

endmodule

// File: rtl/bomb_placer.sv
// Two-player bomb drop scheduler: request edge detection, rule checks,
// round-robin same-cell arbitration and registered placement strobes.
module bomb_placer
  import bomb_pkg::*;
#(
  parameter int unsigned MAX_BOMBS  = 2,
  parameter int unsigned FUSE_TICKS = 4,
  parameter int unsigned COOLDOWN   = 1
) (
  input  logic        bombClk,
  input  logic        rst,
  input  logic        reqA,
  input  logic        reqB,
  input  logic [3:0]  playerAx,
  input  logic [3:0]  playerAy,
  input  logic [3:0]  playerBx,
  input  logic [3:0]  playerBy,
  input  logic [99:0] i_curBombMap_0,
  input  logic [99:0] i_curBombMap_1,
  input  logic [1:0]  game_state,
  output logic        bombA_v,
  output logic        bombB_v,
  output logic [3:0]  bombA_x,
  output logic [3:0]  bombA_y,
  output logic [3:0]  bombB_x,
  output logic [3:0]  bombB_y,
  output logic        rejectA,
  output logic        rejectB,
  output logic [1:0]  activeA,
  output logic [1:0]  activeB
);

  logic       prevA_q, prevB_q;
  logic       prio_b_q, prio_b_d;
  logic       vA_q, vA_d, vB_q, vB_d;
  logic [3:0] xA_q, xA_d, yA_q, yA_d, xB_q, xB_d, yB_q, yB_d;
  logic       rejA_q, rejA_d, rejB_q, rejB_d;

  logic       edgeA, edgeB, inA, inB, emptyA, emptyB;
  logic [6:0] idxA, idxB;
  logic       eligA, eligB, grantA, grantB;
  logic       a_free, a_cool, a_mA, a_mB;
  logic       b_free, b_cool, b_mA, b_mB;

  assign edgeA  = reqA & ~prevA_q;
  assign edgeB  = reqB & ~prevB_q;
  assign inA    = in_grid(playerAx, playerAy);
  assign inB    = in_grid(playerBx, playerBy);
  assign idxA   = inA ? idx(playerAx, playerAy) : '0;
  assign idxB   = inB ? idx(playerBx, playerBy) : '0;
  assign emptyA = ({i_curBombMap_1[idxA], i_curBombMap_0[idxA]} == NONE);
  assign emptyB = ({i_curBombMap_1[idxB], i_curBombMap_0[idxB]} == NONE);

  bomb_slot_tracker #(
    .MAX_BOMBS (MAX_BOMBS),
    .FUSE_TICKS(FUSE_TICKS),
    .COOLDOWN  (COOLDOWN)
  ) u_trk_a (
    .bombClk   (bombClk),
    .rst       (rst),
    .grant_i   (grantA),
    .gx_i      (playerAx),
    .gy_i      (playerAy),
    .qax_i     (playerAx),
    .qay_i     (playerAy),
    .qbx_i     (playerBx),
    .qby_i     (playerBy),
    .has_free_o(a_free),
    .cool_ok_o (a_cool),
    .match_a_o (a_mA),
    .match_b_o (a_mB),
    .active_o  (activeA)
  );

  bomb_slot_tracker #(
    .MAX_BOMBS (MAX_BOMBS),
    .FUSE_TICKS(FUSE_TICKS),
    .COOLDOWN  (COOLDOWN)
  ) u_trk_b (
    .bombClk   (bombClk),
    .rst       (rst),
    .grant_i   (grantB),
    .gx_i      (playerBx),
    .gy_i      (playerBy),
    .qax_i     (playerAx),
    .qay_i     (playerAy),
    .qbx_i     (playerBx),
    .qby_i     (playerBy),
    .has_free_o(b_free),
    .cool_ok_o (b_cool),
    .match_a_o (b_mA),
    .match_b_o (b_mB),
    .active_o  (activeB)
  );

  always_comb begin
    eligA    = edgeA && (game_state == 2'd0) && inA && emptyA && !(a_mA || b_mA)
               && a_free && a_cool;
    eligB    = edgeB && (game_state == 2'd0) && inB && emptyB && !(a_mB || b_mB)
               && b_free && b_cool;
    grantA   = eligA;
    grantB   = eligB;
    prio_b_d = prio_b_q;
    // Same-cell contention: holder wins, priority passes to the loser.
    if (eligA && eligB && playerAx == playerBx && playerAy == playerBy) begin
      grantA   = !prio_b_q;
      grantB   = prio_b_q;
      prio_b_d = !prio_b_q;
    end
    vA_d   = grantA;
    vB_d   = grantB;
    xA_d   = grantA ? playerAx : '0;
    yA_d   = grantA ? playerAy : '0;
    xB_d   = grantB ? playerBx : '0;
    yB_d   = grantB ? playerBy : '0;
    rejA_d = edgeA && !grantA;
    rejB_d = edgeB && !grantB;
  end

  always_ff @(posedge bombClk or posedge rst) begin
    if (rst) begin
      prevA_q  <= 1'b0;
      prevB_q  <= 1'b0;
      prio_b_q <= 1'b0;
      vA_q     <= 1'b0;
      vB_q     <= 1'b0;
      xA_q     <= '0;
      yA_q     <= '0;
      xB_q     <= '0;
      yB_q     <= '0;
      rejA_q   <= 1'b0;
      rejB_q   <= 1'b0;
    end else begin
      prevA_q  <= reqA;
      prevB_q  <= reqB;
      prio_b_q <= prio_b_d;
      vA_q     <= vA_d;
      vB_q     <= vB_d;
      xA_q     <= xA_d;
      yA_q     <= yA_d;
      xB_q     <= xB_d;
      yB_q     <= yB_d;
      rejA_q   <= rejA_d;
      rejB_q   <= rejB_d;
    end
  end

  assign bombA_v = vA_q;
  assign bombB_v = vB_q;
  assign bombA_x = xA_q;
  assign bombA_y = yA_q;
  assign bombB_x = xB_q;
  assign bombB_y = yB_q;
  assign rejectA = rejA_q;
  assign rejectB = rejB_q;

endmodule
